// File: rtl/core_general_pkg.sv
// Shared core definitions: opcode field positions, memory size encodings,
// memory-stage FSM state constants and a misalignment helper.
package core_general_pkg;

  localparam int unsigned OPLEN = 12;

  // Memory-related fields of the decoded opcode vector
  localparam int unsigned MEM_RD_BIT     = 0;
  localparam int unsigned MEM_WR_BIT     = 1;
  localparam int unsigned MEM_SIZE_BIT_L = 2;
  localparam int unsigned MEM_SIZE_BIT_M = 3;
  localparam int unsigned MEM_UNS_BIT    = 4;

  localparam logic [1:0] MEM_SZ_B = 2'b00;
  localparam logic [1:0] MEM_SZ_H = 2'b01;
  localparam logic [1:0] MEM_SZ_W = 2'b10;

  // Memory-stage FSM states
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_DONE   = 2'd2;

  // Natural-alignment check; the unused size code 11 is treated as word
  function automatic logic mem_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    case (size)
      MEM_SZ_B: return 1'b0;
      MEM_SZ_H: return addr_lo[0];
      default:  return addr_lo != 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/memory_access_mem_align.sv
// Combinational data-bus alignment: store lane replication and byte enables,
// load lane extraction with sign/zero extension, and misalignment detection.
module mem_align
  import core_general_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [1:0]      addr_lo,
  input  logic [1:0]      size,
  input  logic            uns,
  input  logic [XLEN-1:0] store_data,
  input  logic [XLEN-1:0] rdata,
  output logic [3:0]      be_c,
  output logic [XLEN-1:0] wdata_c,
  output logic [XLEN-1:0] load_c,
  output logic            misalign_c
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Store side: replicate the datum into every lane it may land in
  always_comb begin
    be_c    = 4'b1111;
    wdata_c = store_data;
    case (size)
      MEM_SZ_B: begin
        be_c    = 4'b0001 << addr_lo;
        wdata_c = XLEN'({4{store_data[7:0]}});
      end
      MEM_SZ_H: begin
        be_c    = addr_lo[1] ? 4'b1100 : 4'b0011;
        wdata_c = XLEN'({2{store_data[15:0]}});
      end
      default: begin
        be_c    = 4'b1111;
        wdata_c = store_data;
      end
    endcase
  end

  // Load side: pick the addressed lane, then extend to XLEN
  always_comb begin
    byte_sel = rdata[7:0];
    case (addr_lo)
      2'd1:    byte_sel = rdata[15:8];
      2'd2:    byte_sel = rdata[23:16];
      2'd3:    byte_sel = rdata[31:24];
      default: byte_sel = rdata[7:0];
    endcase
    half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    case (size)
      MEM_SZ_B: load_c = {{(XLEN-8){byte_sel[7] & ~uns}}, byte_sel};
      MEM_SZ_H: load_c = {{(XLEN-16){half_sel[15] & ~uns}}, half_sel};
      default:  load_c = rdata;
    endcase
  end

  // Misalignment flag for the current size/offset
  always_comb begin
    misalign_c = mem_misaligned(size, addr_lo);
  end

endmodule

// File: rtl/memory_access.sv
// Memory stage: performs the load/store over the req/ack data bus and
// registers results for writeback. Optional bus watchdog enabled by
// defining MEM_BUS_TIMEOUT_EN (adds TIMEOUT_CYC and bus_fault_mw).
module memory_access
  import core_general_pkg::*;
#(
  parameter int unsigned XLEN = 32
`ifdef MEM_BUS_TIMEOUT_EN
  , parameter int unsigned TIMEOUT_CYC = 255
`endif
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             phase_memory,
  input  logic [OPLEN-1:0] decoded_op_em,
  input  logic [4:0]       rdsel_em,
  input  logic [XLEN-1:0]  curr_pc_em,
  input  logic [XLEN-1:0]  alu_out_em,
  input  logic [XLEN-1:0]  rs2data_em,
  input  logic [XLEN-1:0]  csr_out_em,
  input  logic             jump_state_em,
  output logic             d_req,
  output logic             d_we,
  output logic [XLEN-1:0]  d_addr,
  output logic [3:0]       d_be,
  output logic [XLEN-1:0]  d_wdata,
  input  logic [XLEN-1:0]  d_rdata,
  input  logic             d_ack,
  output logic [OPLEN-1:0] decoded_op_mw,
  output logic [4:0]       rdsel_mw,
  output logic [XLEN-1:0]  curr_pc_mw,
  output logic [XLEN-1:0]  alu_out_mw,
  output logic [XLEN-1:0]  csr_out_mw,
  output logic             jump_state_mw,
  output logic [XLEN-1:0]  mem_out_mw,
  output logic             misalign_mw,
`ifdef MEM_BUS_TIMEOUT_EN
  output logic             bus_fault_mw,
`endif
  output logic             stall_memory
);

  logic [1:0]      state, state_next;
  logic            idle_c, entry_c;
  logic            sel_rd, sel_wr, sel_uns;
  logic [1:0]      sel_size, sel_addr_lo;
  logic            is_mem_c, access_c;
  logic [3:0]      be_c;
  logic [XLEN-1:0] wdata_c, load_c;
  logic            misalign_c;

  assign idle_c  = (state == ST_IDLE);
  assign entry_c = idle_c && phase_memory;

  // Alignment sees the live instruction at entry, the captured one afterwards
  assign sel_rd      = idle_c ? decoded_op_em[MEM_RD_BIT]  : decoded_op_mw[MEM_RD_BIT];
  assign sel_wr      = idle_c ? decoded_op_em[MEM_WR_BIT]  : decoded_op_mw[MEM_WR_BIT];
  assign sel_uns     = idle_c ? decoded_op_em[MEM_UNS_BIT] : decoded_op_mw[MEM_UNS_BIT];
  assign sel_size    = idle_c ? decoded_op_em[MEM_SIZE_BIT_M:MEM_SIZE_BIT_L]
                              : decoded_op_mw[MEM_SIZE_BIT_M:MEM_SIZE_BIT_L];
  assign sel_addr_lo = idle_c ? alu_out_em[1:0] : alu_out_mw[1:0];

  assign is_mem_c = sel_rd | sel_wr;
  assign access_c = is_mem_c & ~misalign_c;

  mem_align #(.XLEN(XLEN)) u_align (
    .addr_lo    (sel_addr_lo),
    .size       (sel_size),
    .uns        (sel_uns),
    .store_data (rs2data_em),
    .rdata      (d_rdata),
    .be_c       (be_c),
    .wdata_c    (wdata_c),
    .load_c     (load_c),
    .misalign_c (misalign_c)
  );

  // Stall is combinational so it already covers the phase entry cycle
  assign stall_memory = rst_n && ((entry_c && access_c) || (state == ST_ACCESS));

`ifdef MEM_BUS_TIMEOUT_EN
  logic [7:0] tmo_cnt;
  logic       tmo_hit_c;

  assign tmo_hit_c = (state == ST_ACCESS) && !d_ack && (tmo_cnt == 8'(TIMEOUT_CYC - 1));

  // Watchdog: counts cycles spent waiting in ACCESS
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tmo_cnt <= 8'd0;
    end else if (state != ST_ACCESS) begin
      tmo_cnt <= 8'd0;
    end else begin
      tmo_cnt <= tmo_cnt + 8'd1;
    end
  end
`endif

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (phase_memory) state_next = access_c ? ST_ACCESS : ST_DONE;
      end
      ST_ACCESS: begin
        if (d_ack) state_next = ST_DONE;
`ifdef MEM_BUS_TIMEOUT_EN
        else if (tmo_hit_c) state_next = ST_DONE;
`endif
      end
      ST_DONE: begin
        if (!phase_memory) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Bus request and writeback-facing result registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      d_req         <= 1'b0;
      d_we          <= 1'b0;
      d_addr        <= '0;
      d_be          <= 4'd0;
      d_wdata       <= '0;
      decoded_op_mw <= '0;
      rdsel_mw      <= 5'd0;
      curr_pc_mw    <= '0;
      alu_out_mw    <= '0;
      csr_out_mw    <= '0;
      jump_state_mw <= 1'b0;
      mem_out_mw    <= '0;
      misalign_mw   <= 1'b0;
`ifdef MEM_BUS_TIMEOUT_EN
      bus_fault_mw  <= 1'b0;
`endif
    end else begin
      d_req <= (state_next == ST_ACCESS);
      if (entry_c) begin
        decoded_op_mw <= decoded_op_em;
        rdsel_mw      <= (is_mem_c && misalign_c) ? 5'd0 : rdsel_em;
        curr_pc_mw    <= curr_pc_em;
        alu_out_mw    <= alu_out_em;
        csr_out_mw    <= csr_out_em;
        jump_state_mw <= jump_state_em;
        mem_out_mw    <= '0;
        misalign_mw   <= is_mem_c && misalign_c;
        d_we          <= sel_wr;
        d_addr        <= {alu_out_em[XLEN-1:2], 2'b00};
        d_be          <= be_c;
        d_wdata       <= wdata_c;
`ifdef MEM_BUS_TIMEOUT_EN
        bus_fault_mw  <= 1'b0;
`endif
      end
      if ((state == ST_ACCESS) && d_ack) begin
        mem_out_mw <= sel_rd ? load_c : '0;
      end
`ifdef MEM_BUS_TIMEOUT_EN
      if (tmo_hit_c) begin
        bus_fault_mw <= 1'b1;
        rdsel_mw     <= 5'd0;
        mem_out_mw   <= '0;
      end
`endif
    end
  end

endmodule
